fir_out_fifo: RTL and testbench

Downstream buffering stage for the FIR filter datapath. Consumes the filter's sample/valid pair (D_OUT/R_OUT of the final adder), optionally decimates it, and stores kept samples in a show-ahead FIFO drained by a ready-driven sink. The filter has no backpressure, so this block absorbs rate mismatch and flags any sample lost to a full buffer.

---
 rtl/fir_out_fifo.sv | 94 +++++++++
 tb/tb_fir_out_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_fifo.sv
// Output buffer for the FIR datapath: optional 1-of-DECIM decimation feeding a
// show-ahead FIFO, with a sticky flag for samples lost while the buffer is full.
module fir_out_fifo #(
  parameter int N     = 16,
  parameter int DEPTH = 8,
  parameter int DECIM = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     R_IN,
  input  logic [N-1:0]             D_IN,
  input  logic                     RD_EN,
  output logic                     R_OUT,
  output logic [N-1:0]             D_OUT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     OVF,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_dcnt;
  logic          r_ovf;

  logic w_full;
  logic w_empty;
  logic w_keep;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Handshake: the head transfers on a rising edge when R_OUT=1, RD_EN=1 and
  // EN=1; the source has no ready, so a kept sample arriving while full is dropped
  // unless a pop frees the slot in the same cycle.
  assign w_full  = (r_count == CFULL);
  assign w_empty = (r_count == '0);
  assign w_keep  = EN & R_IN & (r_dcnt == '0);
  assign w_pop   = EN & RD_EN & ~w_empty;
  assign w_push  = w_keep & (~w_full | w_pop);
  assign w_drop  = w_keep & w_full & ~w_pop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dcnt  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      // Decimation phase advances on every enabled input, stored or dropped.
      if (EN & R_IN) begin
        r_dcnt <= (r_dcnt == DLAST) ? '0 : r_dcnt + DW'(1);
      end
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= D_IN;
    end
  end

  assign R_OUT = ~w_empty;
  assign D_OUT = w_empty ? '0 : r_mem[r_rptr];
  assign FULL  = w_full;
  assign EMPTY = w_empty;
  assign OVF   = r_ovf;
  assign COUNT = r_count;

endmodule

// File: tb/tb_fir_out_fifo.sv
// Bench for fir_out_fifo: three instances (DECIM=1,3,2) exercised one at a time,
// with a negedge monitor popping expected head values whenever a pop will occur.
module tb_fir_out_fifo;

  localparam int NI = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NI-1:0]  en;
  logic [NI-1:0]  r_in;
  logic [NI-1:0]  rd_en;
  logic [15:0]    d_in [NI];
  wire  [NI-1:0]  r_out;
  wire  [NI-1:0]  full;
  wire  [NI-1:0]  empty;
  wire  [NI-1:0]  ovf;
  wire  [15:0]    d_out [NI];
  wire  [3:0]     count [NI];

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DEC = (g == 1) ? 3 : ((g == 2) ? 2 : 1);
    fir_out_fifo #(.N(16), .DEPTH(8), .DECIM(DEC)) u_dut (
      .CLK   (clk),
      .RST   (rst),
      .EN    (en[g]),
      .R_IN  (r_in[g]),
      .D_IN  (d_in[g]),
      .RD_EN (rd_en[g]),
      .R_OUT (r_out[g]),
      .D_OUT (d_out[g]),
      .FULL  (full[g]),
      .EMPTY (empty[g]),
      .OVF   (ovf[g]),
      .COUNT (count[g])
    );
  end

  // Monitor: a pop happens at the next rising edge, so the head is compared now.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!rst && en[g] && rd_en[g] && r_out[g]) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected inst=%0d got=%h expected=none", g, d_out[g]);
        end else begin
          mon_exp = exp_q.pop_front();
          if (d_out[g] !== mon_exp) begin
            bad++;
            $display("FAIL pop_data inst=%0d got=%h expected=%h", g, d_out[g], mon_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic cycle(input int g, input bit e, input bit r, input bit rd, input logic [15:0] d);
    en       = '0;
    r_in     = '0;
    rd_en    = '0;
    en[g]    = e;
    r_in[g]  = r;
    rd_en[g] = rd;
    d_in[g]  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int g);
    int n;
    n = 0;
    while (!empty[g] && n < 40) begin
      cycle(g, 1'b1, 1'b0, 1'b1, 16'h0);
      n++;
    end
    cycle(g, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("drain_empty", 32'(empty[g]), 32'd1);
    chk("drain_count", 32'(count[g]), 32'd0);
    chk("drain_sb_left", exp_q.size(), 32'd0);
  endtask

  logic [15:0] dec_v [7] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70};
  bit          dec_k [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  bit          gat_e [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  bit          gat_k [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int occ;
    int sent;
    int n;
    bit push;
    bit pop;

    rst   = 1'b1;
    en    = '0;
    r_in  = '0;
    rd_en = '0;
    for (int g = 0; g < NI; g++) d_in[g] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cycle(0, 1'b0, 1'b0, 1'b0, 16'h0);

    // Reset state
    chk("rst_r_out", 32'(r_out[0]), 32'd0);
    chk("rst_d_out", 32'(d_out[0]), 32'd0);
    chk("rst_empty", 32'(empty[0]), 32'd1);
    chk("rst_full",  32'(full[0]),  32'd0);
    chk("rst_ovf",   32'(ovf[0]),   32'd0);
    chk("rst_count", 32'(count[0]), 32'd0);

    // Fill to full, ninth sample overflows
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(16'(i));
      cycle(0, 1'b1, 1'b1, 1'b0, 16'(i));
      if (i == 1) begin
        chk("first_r_out", 32'(r_out[0]), 32'd1);
        chk("first_head",  32'(d_out[0]), 32'h0001);
      end
      if (i == 7) chk("full_at7", 32'(full[0]), 32'd0);
      if (i == 8) begin
        chk("full_at8",  32'(full[0]),  32'd1);
        chk("count_at8", 32'(count[0]), 32'd8);
        chk("ovf_at8",   32'(ovf[0]),   32'd0);
      end
      if (i == 9) begin
        chk("ovf_at9",   32'(ovf[0]),   32'd1);
        chk("count_at9", 32'(count[0]), 32'd8);
      end
    end
    chk("head_after_ovf", 32'(d_out[0]), 32'h0001);
    drain(0);
    chk("ovf_sticky", 32'(ovf[0]), 32'd1);

    // Asynchronous reset mid-stream with COUNT=3, OVF=1
    for (int i = 0; i < 3; i++) cycle(0, 1'b1, 1'b1, 1'b0, 16'h0050 + 16'(i));
    cycle(0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("pre_rst_count", 32'(count[0]), 32'd3);
    chk("pre_rst_ovf",   32'(ovf[0]),   32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_r_out", 32'(r_out[0]), 32'd0);
    chk("arst_d_out", 32'(d_out[0]), 32'd0);
    chk("arst_empty", 32'(empty[0]), 32'd1);
    chk("arst_count", 32'(count[0]), 32'd0);
    chk("arst_ovf",   32'(ovf[0]),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(16'h0011);
    cycle(0, 1'b1, 1'b1, 1'b0, 16'h0011);
    chk("post_rst_r_out", 32'(r_out[0]), 32'd1);
    chk("post_rst_head",  32'(d_out[0]), 32'h0011);
    drain(0);

    // Full FIFO with simultaneous push and pop
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(16'(i));
      cycle(0, 1'b1, 1'b1, 1'b0, 16'(i));
    end
    chk("sim_pre_full", 32'(full[0]), 32'd1);
    exp_q.push_back(16'h0100);
    cycle(0, 1'b1, 1'b1, 1'b1, 16'h0100);
    chk("sim_count", 32'(count[0]), 32'd8);
    chk("sim_ovf",   32'(ovf[0]),   32'd0);
    chk("sim_head",  32'(d_out[0]), 32'h0002);
    chk("sim_full",  32'(full[0]),  32'd1);
    drain(0);

    // Decimation by 3 keeps 10, 40, 70
    for (int i = 0; i < 7; i++) begin
      if (dec_k[i]) exp_q.push_back(dec_v[i]);
      cycle(1, 1'b1, 1'b1, 1'b0, dec_v[i]);
    end
    cycle(1, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("dec_count", 32'(count[1]), 32'd3);
    chk("dec_head",  32'(d_out[1]), 32'd10);
    drain(1);

    // Enable gating with decimation by 2; RD_EN held high while EN=0
    for (int i = 0; i < 6; i++) begin
      if (gat_k[i]) exp_q.push_back(16'(i + 1));
      cycle(2, gat_e[i], 1'b1, ~gat_e[i], 16'(i + 1));
      if (i == 2) chk("gate_no_pop", 32'(count[2]), 32'd1);
    end
    cycle(2, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("gate_count", 32'(count[2]), 32'd2);
    chk("gate_head",  32'(d_out[2]), 32'd1);
    drain(2);

    // Wrap-around stream, occupancy held within 1..7
    occ  = 0;
    sent = 0;
    n    = 0;
    while (sent < 100 && n < 1000) begin
      push = (occ == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      pop  = (occ > 0)  ? 1'($urandom_range(0, 1)) : 1'b0;
      if (occ >= 7 && push && !pop) pop = 1'b1;
      if (occ <= 1 && pop && !push) pop = 1'b0;
      if (push) exp_q.push_back(16'h1000 + 16'(sent));
      cycle(0, 1'b1, push, pop, 16'h1000 + 16'(sent));
      if (push) sent++;
      occ = occ + int'(push) - int'(pop);
      n++;
    end
    cycle(0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("stream_count", 32'(count[0]), 32'(occ));
    chk("stream_ovf",   32'(ovf[0]),   32'd0);
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout got=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
